// File: rtl/cfu_crc_unit.sv
`default_nettype none
// ============================================================================
// Module      : cfu_crc_unit
// Description : CFU-side CRC-32 accelerator behind the CFU request mux.
//               It keeps NUM_STATES independent CRC-32 accumulators that use
//               the reflected polynomial 0xEDB88320. Bytes are processed one
//               bit per clock. The unit accepts one request at a time and
//               holds each response until the consumer accepts it.
// Ports       : clk, rst                  clock, async active-high reset
//               req_valid / req_ready     request handshake
//               req_state                 accumulator index
//               req_func                  0 INIT, 1 UPDATE, 2 READ, 3 FINAL
//               req_data0 / req_data1     operand / byte count (data1[2:0])
//               req_id                    request tag
//               resp_valid / resp_ready   response handshake
//               resp_status               0 OK, 1 bad func, 2 bad byte count
//               resp_data / resp_id       result and echoed tag
// Revision    : 1.0 - initial release
// ============================================================================
module cfu_crc_unit #(
    parameter int NUM_STATES = 4,
    parameter int STATE_W    = 2,
    parameter int ID_W       = 3,
    parameter int FUNC_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [STATE_W-1:0] req_state,
    input  logic [FUNC_W-1:0] req_func,
    input  logic [31:0]       req_data0,
    input  logic [31:0]       req_data1,
    input  logic [ID_W-1:0]   req_id,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [2:0]        resp_status,
    output logic [31:0]       resp_data,
    output logic [ID_W-1:0]   resp_id
);

    localparam int          IDX_W     = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1;
    localparam logic [31:0] C_POLY    = 32'hEDB8_8320;
    localparam logic [2:0]  C_ST_OK   = 3'd0;
    localparam logic [2:0]  C_ST_FUNC = 3'd1;
    localparam logic [2:0]  C_ST_CNT  = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_req_ready;
    logic                r_resp_valid;
    logic [2:0]          r_resp_status;
    logic [31:0]         r_resp_data;
    logic [ID_W-1:0]     r_resp_id;
    logic [31:0]         r_acc [NUM_STATES];
    logic [IDX_W-1:0]    r_idx;
    logic [31:0]         r_shift;
    logic [4:0]          r_bit_cnt;
    logic [4:0]          r_last_bit;

    logic                w_accept;
    logic [IDX_W-1:0]    w_req_idx;
    logic [2:0]          w_count;
    logic                w_count_ok;
    logic [31:0]         w_cur_acc;
    logic [31:0]         w_c;
    logic [31:0]         w_next_acc;
    logic                w_unused_bits;

    assign w_accept   = req_valid & r_req_ready;
    // Index is truncated to the accumulator address width; a single-context
    // build always addresses entry 0.
    assign w_req_idx  = (NUM_STATES > 1) ? req_state[IDX_W-1:0] : '0;
    assign w_count    = req_data1[2:0];
    assign w_count_ok = (w_count != 3'd0) && (w_count <= 3'd4);

    // One bit of the reflected CRC-32 per SHIFT cycle, LSB first.
    assign w_cur_acc  = r_acc[r_idx];
    assign w_c        = w_cur_acc ^ {31'd0, r_shift[0]};
    assign w_next_acc = (w_cur_acc >> 1) ^ (w_c[0] ? C_POLY : 32'd0);

    // Only the byte count field of data1 and the low index bits matter.
    assign w_unused_bits = ^{req_data1[31:3], req_state};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_req_ready   <= 1'b1;
            r_resp_valid  <= 1'b0;
            r_resp_status <= C_ST_OK;
            r_resp_data   <= 32'd0;
            r_resp_id     <= '0;
            r_idx         <= '0;
            r_shift       <= 32'd0;
            r_bit_cnt     <= 5'd0;
            r_last_bit    <= 5'd0;
            for (int i = 0; i < NUM_STATES; i++) begin
                r_acc[i] <= 32'hFFFF_FFFF;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_resp_id   <= req_id;
                        r_idx       <= w_req_idx;
                        case (req_func)
                            FUNC_W'(0): begin
                                r_acc[w_req_idx] <= req_data0;
                                r_resp_data      <= req_data0;
                                r_resp_status    <= C_ST_OK;
                                r_resp_valid     <= 1'b1;
                                r_state          <= ST_RESP;
                            end
                            FUNC_W'(1): begin
                                if (w_count_ok) begin
                                    r_shift    <= req_data0;
                                    r_bit_cnt  <= 5'd0;
                                    // Last bit index = 8*n - 1 for n in 1..4.
                                    r_last_bit <= {w_count[1:0] - 2'd1, 3'b111};
                                    r_state    <= ST_SHIFT;
                                end else begin
                                    r_resp_data   <= r_acc[w_req_idx];
                                    r_resp_status <= C_ST_CNT;
                                    r_resp_valid  <= 1'b1;
                                    r_state       <= ST_RESP;
                                end
                            end
                            FUNC_W'(2): begin
                                r_resp_data   <= r_acc[w_req_idx];
                                r_resp_status <= C_ST_OK;
                                r_resp_valid  <= 1'b1;
                                r_state       <= ST_RESP;
                            end
                            FUNC_W'(3): begin
                                r_resp_data   <= ~r_acc[w_req_idx];
                                r_resp_status <= C_ST_OK;
                                r_resp_valid  <= 1'b1;
                                r_state       <= ST_RESP;
                            end
                            default: begin
                                r_resp_data   <= 32'd0;
                                r_resp_status <= C_ST_FUNC;
                                r_resp_valid  <= 1'b1;
                                r_state       <= ST_RESP;
                            end
                        endcase
                    end
                end
                ST_SHIFT: begin
                    r_acc[r_idx] <= w_next_acc;
                    r_shift      <= r_shift >> 1;
                    r_bit_cnt    <= r_bit_cnt + 5'd1;
                    if (r_bit_cnt == r_last_bit) begin
                        r_resp_data   <= w_next_acc;
                        r_resp_status <= C_ST_OK;
                        r_resp_valid  <= 1'b1;
                        r_state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_status = r_resp_status;
    assign resp_data   = r_resp_data;
    assign resp_id     = r_resp_id;

endmodule
`default_nettype wire

// File: tb/tb_cfu_crc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cfu_crc_unit
// Description : Directed self-checking bench for cfu_crc_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cfu_crc_unit;

    localparam logic [31:0] C_POLY = 32'hEDB8_8320;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_state;
    logic [2:0]  req_func;
    logic [31:0] req_data0;
    logic [31:0] req_data1;
    logic [2:0]  req_id;
    logic        resp_valid;
    logic        resp_ready;
    logic [2:0]  resp_status;
    logic [31:0] resp_data;
    logic [2:0]  resp_id;

    int vectors;
    int miscompares;

    cfu_crc_unit #(
        .NUM_STATES(4),
        .STATE_W   (2),
        .ID_W      (3),
        .FUNC_W    (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_state  (req_state),
        .req_func   (req_func),
        .req_data0  (req_data0),
        .req_data1  (req_data1),
        .req_id     (req_id),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_status(resp_status),
        .resp_data  (resp_data),
        .resp_id    (resp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference reflected CRC-32 over the low n bytes of d.
    function automatic logic [31:0] crc_model(input logic [31:0] acc,
                                              input logic [31:0] d,
                                              input int n);
        logic [31:0] a;
        logic        c;
        a = acc;
        for (int i = 0; i < n * 8; i++) begin
            c = a[0] ^ d[i];
            a = (a >> 1) ^ (c ? C_POLY : 32'd0);
        end
        return a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request with resp_ready held high and returns the response
    // fields plus the number of edges from accept to resp_valid.
    task automatic do_req(input logic [2:0] func, input logic [1:0] st,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [2:0] id,
                          output logic [2:0] status, output logic [31:0] data,
                          output logic [2:0] rid, output int lat);
        int guard;
        guard = 0;
        while (!req_ready && guard < 200) begin
            step();
            guard++;
        end
        if (!req_ready) begin
            vectors++;
            miscompares++;
            $error("FAIL ready_timeout: observed 0 expected 1");
        end
        req_valid = 1'b1;
        req_func  = func;
        req_state = st;
        req_data0 = d0;
        req_data1 = d1;
        req_id    = id;
        step();
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 100) begin
            step();
            lat++;
        end
        if (!resp_valid) begin
            vectors++;
            miscompares++;
            $error("FAIL resp_timeout: observed 0 expected 1");
        end
        status = resp_status;
        data   = resp_data;
        rid    = resp_id;
        step();
    endtask

    logic [2:0]  s;
    logic [31:0] d;
    logic [2:0]  rid;
    int          lat;
    logic [31:0] exp_acc;
    int          hs;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_func    = 3'd0;
        req_state   = 2'd0;
        req_data0   = 32'd0;
        req_data1   = 32'd0;
        req_id      = 3'd0;
        resp_ready  = 1'b1;
        step();
        step();
        check("rst_req_ready",   32'(req_ready),   32'd1);
        check("rst_resp_valid",  32'(resp_valid),  32'd0);
        check("rst_resp_status", 32'(resp_status), 32'd0);
        check("rst_resp_data",   resp_data,        32'd0);
        check("rst_resp_id",     32'(resp_id),     32'd0);
        rst = 1'b0;
        step();

        // READ of a fresh accumulator.
        do_req(3'd2, 2'd0, 32'd0, 32'd0, 3'd5, s, d, rid, lat);
        check("read0_data",   d,         32'hFFFF_FFFF);
        check("read0_status", 32'(s),    32'd0);
        check("read0_id",     32'(rid),  32'd5);
        check("read0_lat",    32'(lat),  32'd1);

        // CRC-32 of "123456789" in context 1.
        do_req(3'd0, 2'd1, 32'hFFFF_FFFF, 32'd0, 3'd1, s, d, rid, lat);
        check("init1_data", d,        32'hFFFF_FFFF);
        check("init1_lat",  32'(lat), 32'd1);
        exp_acc = crc_model(32'hFFFF_FFFF, 32'h3433_3231, 4);
        do_req(3'd1, 2'd1, 32'h3433_3231, 32'd4, 3'd2, s, d, rid, lat);
        check("upd_1234_data", d,        exp_acc);
        check("upd_1234_lat",  32'(lat), 32'd33);
        check("upd_1234_id",   32'(rid), 32'd2);
        exp_acc = crc_model(exp_acc, 32'h3837_3635, 4);
        do_req(3'd1, 2'd1, 32'h3837_3635, 32'd4, 3'd3, s, d, rid, lat);
        check("upd_5678_data", d,        exp_acc);
        check("upd_5678_lat",  32'(lat), 32'd33);
        do_req(3'd1, 2'd1, 32'h0000_0039, 32'd1, 3'd4, s, d, rid, lat);
        check("upd_9_data", d,        32'h340B_C6D9);
        check("upd_9_lat",  32'(lat), 32'd9);
        do_req(3'd3, 2'd1, 32'd0, 32'd0, 3'd6, s, d, rid, lat);
        check("final1_data",   d,        32'hCBF4_3926);
        check("final1_status", 32'(s),   32'd0);
        check("final1_lat",    32'(lat), 32'd1);

        // CRC-32 of "a" in context 2, then context 1 must be untouched.
        do_req(3'd0, 2'd2, 32'hFFFF_FFFF, 32'd0, 3'd0, s, d, rid, lat);
        do_req(3'd1, 2'd2, 32'h0000_0061, 32'd1, 3'd1, s, d, rid, lat);
        check("upd_a_data", d,        32'h1748_41BC);
        check("upd_a_lat",  32'(lat), 32'd9);
        do_req(3'd3, 2'd2, 32'd0, 32'd0, 3'd2, s, d, rid, lat);
        check("final2_data", d, 32'hE8B7_BE43);
        do_req(3'd2, 2'd1, 32'd0, 32'd0, 3'd3, s, d, rid, lat);
        check("read1_indep", d, 32'h340B_C6D9);

        // Illegal byte counts and illegal funcs.
        do_req(3'd1, 2'd1, 32'hDEAD_BEEF, 32'd0, 3'd4, s, d, rid, lat);
        check("cnt0_status", 32'(s),   32'd2);
        check("cnt0_data",   d,        32'h340B_C6D9);
        check("cnt0_lat",    32'(lat), 32'd1);
        do_req(3'd1, 2'd1, 32'hDEAD_BEEF, 32'd5, 3'd5, s, d, rid, lat);
        check("cnt5_status", 32'(s), 32'd2);
        check("cnt5_data",   d,      32'h340B_C6D9);
        do_req(3'd2, 2'd1, 32'd0, 32'd0, 3'd6, s, d, rid, lat);
        check("cnt_err_unchanged", d, 32'h340B_C6D9);
        do_req(3'd6, 2'd1, 32'h1234_5678, 32'd2, 3'd7, s, d, rid, lat);
        check("func6_status", 32'(s),   32'd1);
        check("func6_data",   d,        32'd0);
        check("func6_id",     32'(rid), 32'd7);
        check("func6_lat",    32'(lat), 32'd1);
        do_req(3'd4, 2'd2, 32'd0, 32'd0, 3'd1, s, d, rid, lat);
        check("func4_status", 32'(s), 32'd1);
        do_req(3'd2, 2'd1, 32'd0, 32'd0, 3'd2, s, d, rid, lat);
        check("func_err_unchanged", d, 32'h340B_C6D9);

        // Back-pressure on the response channel.
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_func   = 3'd2;
        req_state  = 2'd2;
        req_id     = 3'd3;
        step();
        req_valid = 1'b0;
        step();
        for (int i = 0; i < 10; i++) begin
            check("bp_valid",     32'(resp_valid), 32'd1);
            check("bp_data",      resp_data,       32'h1748_41BC);
            check("bp_id",        32'(resp_id),    32'd3);
            check("bp_req_ready", 32'(req_ready),  32'd0);
            step();
        end
        resp_ready = 1'b1;
        hs = 0;
        for (int i = 0; i < 5; i++) begin
            if (resp_valid && resp_ready) hs++;
            if (i == 1) check("bp_ready_after", 32'(req_ready), 32'd1);
            step();
        end
        check("bp_handshakes", 32'(hs), 32'd1);

        // Reset in the middle of an UPDATE.
        req_valid = 1'b1;
        req_func  = 3'd1;
        req_state = 2'd1;
        req_data0 = 32'h3433_3231;
        req_data1 = 32'd4;
        req_id    = 3'd1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("mid_busy", 32'(req_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(req_ready),  32'd1);
        check("mid_rst_valid", 32'(resp_valid), 32'd0);
        step();
        rst = 1'b0;
        step();
        check("mid_rst_quiet", 32'(resp_valid), 32'd0);
        do_req(3'd2, 2'd1, 32'd0, 32'd0, 3'd2, s, d, rid, lat);
        check("post_rst_read1", d, 32'hFFFF_FFFF);
        do_req(3'd2, 2'd2, 32'd0, 32'd0, 3'd3, s, d, rid, lat);
        check("post_rst_read2", d, 32'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cfu_crc_unit.md
Name: cfu_crc_unit

Overview:
- CFU-side CRC-32 accelerator that sits directly downstream of the CFU request mux. It consumes the CRC-select request leg and produces responses back to the mux.
- Keeps NUM_STATES independent CRC-32 accumulators, selected by req_state.
- Uses reflected polynomial 0xEDB88320 and processes bytes bit-serially.
- Accepts one request at a time and holds each response until it is accepted.

Parameters:
- NUM_STATES, 4, number of CRC accumulator contexts (power of 2, at least 1).
- STATE_W, 2, width of req_state.
- ID_W, 3, width of req_id/resp_id.
- FUNC_W, 3, width of req_func.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  unit can accept a request.
- req_state  in  STATE_W  accumulator index.
- req_func  in  FUNC_W  operation code.
- req_data0  in  32  operand 0.
- req_data1  in  32  operand 1.
- req_id  in  ID_W  request tag.
- resp_valid  out  1  response valid.
- resp_ready  in  1  consumer accepts response.
- resp_status  out  3  0 = OK, 1 = illegal func, 2 = illegal byte count.
- resp_data  out  32  result.
- resp_id  out  ID_W  echoed req_id.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: FSM = IDLE, req_ready = 1, resp_valid = 0, resp_status = 0, resp_data = 0, resp_id = 0, all accumulators = 0xFFFFFFFF.
- Reset mid-operation: an in-flight request is abandoned with no response; accumulators return to 0xFFFFFFFF.
- FSM states: IDLE, SHIFT, RESP.
- req_ready = (state == IDLE). It is registered, not a combinational function of req_valid.
- Accept condition: req_valid & req_ready on a rising edge. On accept, latch func, state index, data0, data1 and id.
- func 0 INIT: acc[idx] <= data0. Response data = data0.
- func 1 UPDATE: process data1[2:0] bytes of data0, LSB byte first; legal count is 1..4.
  - Count 0 or greater than 4: no update, status 2, data = acc[idx].
  - Legal count: go to SHIFT for 8 × count cycles, one bit per cycle, LSB first.
  - Per-bit step: c = acc ^ bit; acc = (acc >> 1) ^ (c[0] ? 0xEDB88320 : 0).
  - After the last bit, response data = updated acc[idx].
- func 2 READ: data = acc[idx].
- func 3 FINAL: data = acc[idx] ^ 0xFFFFFFFF. The accumulator is unchanged.
- func 4..7: status 1, no state change, data = 0.
- Latency, accept to resp_valid:
  - INIT, READ, FINAL and all errors: 1 cycle (IDLE → RESP).
  - UPDATE: 8·n + 1 cycles.
- RESP state: resp_valid = 1; resp_data, resp_status and resp_id stay stable until resp_valid & resp_ready. Then go to IDLE, and req_ready = 1 on the following cycle.
- Back-pressure: if resp_ready stays low, the unit stays in RESP indefinitely with req_ready = 0. No request is dropped.
- req_state ≥ NUM_STATES is impossible for a power-of-2 NUM_STATES; the index is truncated to log2(NUM_STATES) bits.
- Accumulators for other indices are never touched by an operation on idx.
- A req_valid asserted while req_ready = 0 is ignored; it is the upstream's job to hold it.
- Bit counter: 5 bits, counting 0..31. Byte shift register: 32 bits, shifted right one place each SHIFT cycle.

Test Plan:
- Reset, then READ state 0 → resp_data = 0xFFFFFFFF, status 0, resp_id echoed, latency 1 cycle.
- INIT state 1 with 0xFFFFFFFF; UPDATE with data0 = 0x34333231, n = 4 ("1234"); UPDATE 0x38373635, n = 4; UPDATE 0x39, n = 1; FINAL → 0xCBF43926 (CRC-32 of "123456789"); UPDATE latencies 33/33/9 cycles.
- INIT state 2 with 0xFFFFFFFF, UPDATE 0x61, n = 1, FINAL → 0xE8B7BE43. READ state 1 afterwards → unchanged from the prior test (independence).
- UPDATE with n = 0 and with n = 5 → status 2, accumulator unchanged. func 6 → status 1, data 0.
- Hold resp_ready = 0 for 10 cycles during RESP → resp_valid and data stable, req_ready = 0. Release → exactly one handshake, then req_ready returns to 1 one cycle later.
- Assert rst for one cycle midway through an UPDATE → immediate IDLE, req_ready = 1, resp_valid = 0. A subsequent READ returns 0xFFFFFFFF.
